// File: rtl/base64_encode_ctrl_pkg.sv
// Shared Base64 definitions: FSM states, pad symbol, alphabet ordering and
// the helper that slices a 24-bit byte group into its four 6-bit indices.
package base64_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } b64_state_e;

    localparam logic [7:0] PAD_CHAR = 8'h3D;

    // Index 0 sits in the most significant byte.
    localparam logic [8*64-1:0] B64_ALPHABET =
        "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";

    function automatic logic [5:0] sextet_of(input logic [23:0] grp, input logic [1:0] k);
        logic [5:0] s;
        case (k)
            2'd0:    s = grp[23:18];
            2'd1:    s = grp[17:12];
            2'd2:    s = grp[11:6];
            default: s = grp[5:0];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/base64_encode_ctrl_if.sv
// Byte-in / symbol-out handshake bundle of the Base64 encoder.
// slave is the encoder side, master is the producer/consumer side.
interface base64_encode_ctrl_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    logic       out_valid;
    logic [5:0] out_sextet;
    logic [7:0] out_char;
    logic       out_pad;
    logic       out_last;
    logic       out_eol;
    logic       out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sextet, out_char, out_pad, out_last, out_eol
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sextet, out_char, out_pad, out_last, out_eol
    );

endinterface

// File: rtl/base64_encode_ctrl_char_lut.sv
// Combinational Base64 index-to-ASCII lookup (standard alphabet), zero latency.
module base64_char_lut
    import base64_pkg::*;
(
    input  logic [5:0] idx_i,
    output logic [7:0] char_o
);

    assign char_o = B64_ALPHABET[{6'd63 - idx_i, 3'b000} +: 8];

endmodule

// File: rtl/base64_encode_ctrl.sv
// Base64 encoder: collects up to 3 bytes, then emits 4 symbols; first symbol valid
// one cycle after the group-completing byte; out_ready stalls hold the symbol, no overlap.
module base64_encode_ctrl
    import base64_pkg::*;
#(
    parameter int LINE_LEN = 76
) (
    input  logic                 clk,
    input  logic                 rst,
    base64_encode_ctrl_if.slave  bus
);

    localparam int              LW       = (LINE_LEN > 0) ? $clog2(LINE_LEN + 1) : 1;
    localparam logic [LW-1:0]   LINE_MAX = LW'((LINE_LEN > 0) ? LINE_LEN - 1 : 0);

    b64_state_e     state_q, state_d;
    logic [23:0]    grp_q, grp_d;
    logic [1:0]     nb_q, nb_d;
    logic [1:0]     k_q, k_d;
    logic           last_q, last_d;
    logic [LW-1:0]  line_q, line_d;

    logic           in_fire;
    logic           out_fire;
    logic           sym_pad;
    logic           sym_last;
    logic           sym_eol;
    logic [5:0]     sym_sextet;
    logic [7:0]     lut_char;

    assign bus.in_ready  = rst && (state_q == COLLECT);
    assign bus.out_valid = (state_q == EMIT);
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Symbol fields are forced to index 0 outside EMIT so an idle encoder shows 'A'.
    always_comb begin
        sym_pad    = 1'b0;
        sym_sextet = 6'd0;
        sym_last   = 1'b0;
        sym_eol    = 1'b0;
        if (state_q == EMIT) begin
            sym_pad    = (k_q > nb_q);
            sym_sextet = sym_pad ? 6'd0 : sextet_of(grp_q, k_q);
            sym_last   = last_q && (k_q == 2'd3);
            sym_eol    = sym_last || ((LINE_LEN > 0) && (line_q == LINE_MAX));
        end
    end

    base64_char_lut u_lut (
        .idx_i  (sym_sextet),
        .char_o (lut_char)
    );

    assign bus.out_sextet = sym_sextet;
    assign bus.out_char   = sym_pad ? PAD_CHAR : lut_char;
    assign bus.out_pad    = sym_pad;
    assign bus.out_last   = sym_last;
    assign bus.out_eol    = sym_eol;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        nb_d    = nb_q;
        k_d     = k_q;
        last_d  = last_q;
        line_d  = line_q;
        case (state_q)
            COLLECT: begin
                if (in_fire) begin
                    case (nb_q)
                        2'd0:    grp_d[23:16] = bus.in_data;
                        2'd1:    grp_d[15:8]  = bus.in_data;
                        default: grp_d[7:0]   = bus.in_data;
                    endcase
                    nb_d = nb_q + 2'd1;
                    if ((nb_q == 2'd2) || bus.in_last) begin
                        state_d = EMIT;
                        k_d     = 2'd0;
                        last_d  = bus.in_last;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    k_d    = k_q + 2'd1;
                    line_d = (sym_eol || (LINE_LEN == 0)) ? '0 : line_q + 1'b1;
                    if (k_q == 2'd3) begin
                        state_d = COLLECT;
                        grp_d   = '0;
                        nb_d    = 2'd0;
                        k_d     = 2'd0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            grp_q   <= '0;
            nb_q    <= 2'd0;
            k_q     <= 2'd0;
            last_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            nb_q    <= nb_d;
            k_q     <= k_d;
            last_q  <= last_d;
            line_q  <= line_d;
        end
    end

    // A stalled symbol must not change under the consumer.
    a_hold_stalled: assert property (@(posedge clk) disable iff (!rst)
        (bus.out_valid && !bus.out_ready) |=>
            $stable({bus.out_sextet, bus.out_char, bus.out_pad, bus.out_last, bus.out_eol}));

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
        !(bus.in_ready && bus.out_valid));

endmodule

// File: tb/tb_base64_encode_ctrl.sv
// Bench for base64_encode_ctrl: three instances (LINE_LEN 4, 76, 0) share stimulus
// and are scored against a queue-based Base64 reference model.
module tb_base64_encode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    always #5 clk = ~clk;

    base64_encode_ctrl_if if4 ();
    base64_encode_ctrl_if if76 ();
    base64_encode_ctrl_if if0 ();

    assign if4.in_valid   = in_valid;
    assign if4.in_data    = in_data;
    assign if4.in_last    = in_last;
    assign if4.out_ready  = out_ready;
    assign if76.in_valid  = in_valid;
    assign if76.in_data   = in_data;
    assign if76.in_last   = in_last;
    assign if76.out_ready = out_ready;
    assign if0.in_valid   = in_valid;
    assign if0.in_data    = in_data;
    assign if0.in_last    = in_last;
    assign if0.out_ready  = out_ready;

    base64_encode_ctrl #(.LINE_LEN(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    base64_encode_ctrl                 u_dut76 (.clk(clk), .rst(rst), .bus(if76));
    base64_encode_ctrl #(.LINE_LEN(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

    typedef struct packed {
        logic       ov;
        logic       ir;
        logic [5:0] sx;
        logic [7:0] ch;
        logic       pd;
        logic       ls;
        logic       eo;
    } obs_t;

    typedef struct packed {
        logic [5:0] sx;
        logic [7:0] ch;
        logic       pd;
        logic       ls;
        logic [2:0] eo;   // per instance: [0] LINE_LEN=4, [1] 76, [2] 0
    } exp_t;

    obs_t obs [3];
    assign obs[0] = {if4.out_valid, if4.in_ready, if4.out_sextet, if4.out_char,
                     if4.out_pad, if4.out_last, if4.out_eol};
    assign obs[1] = {if76.out_valid, if76.in_ready, if76.out_sextet, if76.out_char,
                     if76.out_pad, if76.out_last, if76.out_eol};
    assign obs[2] = {if0.out_valid, if0.in_ready, if0.out_sextet, if0.out_char,
                     if0.out_pad, if0.out_last, if0.out_eol};

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  tx_q [$];
    bit          txl_q [$];
    exp_t        exp_q [$];
    int          mg [3];
    int          mgn;
    int          cnt4;
    int          cnt76;
    int          pend;
    int          gcnt;
    logic [63:0] got;
    logic [15:0] eol_hist;

    function automatic logic [7:0] b64_char(input int s);
        if (s < 26)      return 8'(65 + s);
        else if (s < 52) return 8'(97 + s - 26);
        else if (s < 62) return 8'(48 + s - 52);
        else if (s == 62) return 8'h2B;
        else             return 8'h2F;
    endfunction

    task automatic model_reset();
        tx_q.delete();
        txl_q.delete();
        exp_q.delete();
        mg    = '{0, 0, 0};
        mgn   = 0;
        cnt4  = 0;
        cnt76 = 0;
        pend  = 0;
        gcnt  = 0;
    endtask

    task automatic model_group(input bit last);
        int   v;
        exp_t e;
        v = (mg[0] << 16) | (mg[1] << 8) | mg[2];
        for (int k = 0; k < 4; k++) begin
            e.pd    = (k > mgn);
            e.sx    = e.pd ? 6'd0 : 6'((v >> (18 - 6 * k)) & 63);
            e.ch    = e.pd ? 8'h3D : b64_char(int'(e.sx));
            e.ls    = last && (k == 3);
            e.eo[0] = e.ls || (cnt4 == 3);
            e.eo[1] = e.ls || (cnt76 == 75);
            e.eo[2] = e.ls;
            cnt4    = e.eo[0] ? 0 : cnt4 + 1;
            cnt76   = e.eo[1] ? 0 : cnt76 + 1;
            exp_q.push_back(e);
        end
        mg  = '{0, 0, 0};
        mgn = 0;
    endtask

    task automatic add_byte(input logic [7:0] b, input bit last);
        tx_q.push_back(b);
        txl_q.push_back(last);
        mg[mgn] = int'(b);
        mgn++;
        if (mgn == 3 || last) model_group(last);
    endtask

    task automatic push_str(input logic [63:0] s, input int len);
        for (int i = 0; i < len; i++) add_byte(s[8 * (len - 1 - i) +: 8], i == len - 1);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) add_byte(8'($urandom), i == n - 1);
    endtask

    // Drains queued bytes/symbols; mode 0: out_ready high, 1: toggling, 2: random.
    task automatic run(input int mode);
        int cyc = 0;
        bit tog = 1'b0;
        bit lst;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = tog;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (tx_q.size() != 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data  = tx_q[0];
                in_last  = txl_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'b0;
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                tests++;
                if (obs[j].ov !== (pend > 0) || obs[j].ir !== (pend == 0)) begin
                    fails++;
                    $display("FAIL handshake dut%0d cyc%0d: out_valid=%b in_ready=%b, want out_valid=%b in_ready=%b",
                             j, cyc, obs[j].ov, obs[j].ir, pend > 0, pend == 0);
                end
                if (pend > 0) begin
                    tests++;
                    if (obs[j].sx !== exp_q[0].sx || obs[j].ch !== exp_q[0].ch ||
                        obs[j].pd !== exp_q[0].pd || obs[j].ls !== exp_q[0].ls ||
                        obs[j].eo !== exp_q[0].eo[j]) begin
                        fails++;
                        $display("FAIL symbol dut%0d cyc%0d: sx=%0d ch=%h pad=%b last=%b eol=%b, want sx=%0d ch=%h pad=%b last=%b eol=%b",
                                 j, cyc, obs[j].sx, obs[j].ch, obs[j].pd, obs[j].ls, obs[j].eo,
                                 exp_q[0].sx, exp_q[0].ch, exp_q[0].pd, exp_q[0].ls, exp_q[0].eo[j]);
                    end
                end
            end
            if (pend > 0) begin
                if (out_ready) begin
                    got      = {got[55:0], obs[0].ch};
                    eol_hist = {eol_hist[14:0], obs[0].eo};
                    void'(exp_q.pop_front());
                    pend--;
                end
            end else if (in_valid) begin
                lst = txl_q[0];
                void'(tx_q.pop_front());
                void'(txl_q.pop_front());
                gcnt++;
                if (gcnt == 3 || lst) begin
                    pend = 4;
                    gcnt = 0;
                end
            end
            cyc++;
        end
        tests++;
        if (tx_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d bytes and %0d symbols left, want 0 and 0",
                     tx_q.size(), exp_q.size());
            model_reset();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        obs_t want;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        want = {1'b0, 1'b0, 6'd0, 8'h41, 3'b000};
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j] !== want) begin
                fails++;
                $display("FAIL reset_held dut%0d: got %h, want %h", j, obs[j], want);
            end
        end
        rst = 1'b1;
        #1;
        want = {1'b0, 1'b1, 6'd0, 8'h41, 3'b000};
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j] !== want) begin
                fails++;
                $display("FAIL reset_released dut%0d: got %h, want %h", j, obs[j], want);
            end
        end
    endtask

    task automatic test_man();
        got = '0;
        push_str(64'h4D616E, 3);
        run(0);
        tests++;
        if (got[31:0] !== "TWFu") begin
            fails++;
            $display("FAIL man_string: got %h, want %h", got[31:0], "TWFu");
        end
    endtask

    task automatic test_padding();
        got = '0;
        push_str(64'h4D, 1);
        run(0);
        tests++;
        if (got[31:0] !== "TQ==") begin
            fails++;
            $display("FAIL pad_two: got %h, want %h", got[31:0], "TQ==");
        end
        got = '0;
        push_str(64'h4D61, 2);
        run(0);
        tests++;
        if (got[31:0] !== "TWE=") begin
            fails++;
            $display("FAIL pad_one: got %h, want %h", got[31:0], "TWE=");
        end
        got = '0;
        push_str(64'h4D616E, 3);
        run(0);
        tests++;
        if (got[31:0] !== "TWFu") begin
            fails++;
            $display("FAIL pad_then_full: got %h, want %h", got[31:0], "TWFu");
        end
    endtask

    task automatic test_line_stall();
        for (int m = 0; m < 2; m++) begin
            got      = '0;
            eol_hist = '0;
            push_str(64'h4D616E4D616E, 6);
            run(m);
            tests++;
            if (got !== "TWFuTWFu") begin
                fails++;
                $display("FAIL line_string mode%0d: got %h, want %h", m, got, "TWFuTWFu");
            end
            tests++;
            if (eol_hist[7:0] !== 8'b0001_0001) begin
                fails++;
                $display("FAIL line_eol mode%0d: got %b, want 00010001", m, eol_hist[7:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 10; m++) push_rand(int'($urandom_range(1, 10)));
        push_rand(60);
        for (int m = 0; m < 4; m++) push_rand(int'($urandom_range(1, 8)));
        run(2);
    endtask

    task automatic test_reset_mid_emit();
        logic [23:0] man;
        obs_t        want;
        man       = 24'h4D616E;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = man[8 * (2 - i) +: 8];
            in_last  = (i == 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j].ov !== 1'b1 || obs[j].sx !== 6'd19) begin
                fails++;
                $display("FAIL mid_k0 dut%0d: out_valid=%b sx=%0d, want 1 and 19", j, obs[j].ov, obs[j].sx);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j].ov !== 1'b1 || obs[j].sx !== 6'd22) begin
                fails++;
                $display("FAIL mid_k1 dut%0d: out_valid=%b sx=%0d, want 1 and 22", j, obs[j].ov, obs[j].sx);
            end
        end
        rst = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j].ov !== 1'b0 || obs[j].ir !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset dut%0d: out_valid=%b in_ready=%b, want 0 and 0", j, obs[j].ov, obs[j].ir);
            end
        end
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        want = {1'b0, 1'b1, 6'd0, 8'h41, 3'b000};
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (obs[j] !== want) begin
                fails++;
                $display("FAIL mid_release dut%0d: got %h, want %h", j, obs[j], want);
            end
        end
        model_reset();
        got = '0;
        push_str(64'h4D, 1);
        run(0);
        tests++;
        if (got[31:0] !== "TQ==") begin
            fails++;
            $display("FAIL mid_recover: got %h, want %h", got[31:0], "TQ==");
        end
    endtask

    initial begin
        test_reset();
        test_man();
        test_padding();
        test_line_stall();
        test_random();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
